interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Latches, masks and prioritises peripheral interrupt lines and sequences their delivery to the CPU core. It sits beside the control unit: it raises a single request to the fetch/PC logic, captures the serviced line's ID for the INTID instruction, and returns to idle when the core executes RETI. Nesting is not supported: one interrupt is in service at a time.

## Interface
- `N_IRQ`, 8: number of interrupt lines, 1..32.
- `ID_W`, 8: width of `int_id`; must satisfy 2^`ID_W` >= `N_IRQ`.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `irq`  in  `N_IRQ`  interrupt lines, synchronous to `clk`, rising-edge triggered.
- `mask_we`  in  1  write-enable for the enable mask.
- `mask_wdata`  in  `N_IRQ`  new enable mask (1 = enabled).
- `int_ack`  in  1  one-cycle pulse from the core when it takes the interrupt (PC saved, redirect committed).
- `reti`  in  1  one-cycle pulse when RETI commits.
- `int_req`  out  1  registered interrupt request to the core.
- `int_id`  out  `ID_W`  index of the line currently or last serviced; read by INTID.
- `in_service`  out  1  high from accepted ack until RETI.
- `pending`  out  `N_IRQ`  latched pending bits, for debug.

## Operation
- Edge detect: `irq_prev` register; `edge = irq & ~irq_prev`. `irq_prev` resets to 0, so a line already high when reset releases produces one edge.
- Pending: for each line, `pending[i]` is set on `edge[i]` and cleared on an accepted ack that selects line i. When both happen in the same cycle, set wins and the bit stays 1.
- Masked lines still latch pending. They only become eligible once enabled. A mask write takes effect for the request decision in the following cycle.
- Eligible = `pending & mask`. Priority is fixed: the lowest index wins.
- State machine with two states:
  - IDLE: `int_req` <= (eligible != 0). An ack while `int_req`=1 moves to BUSY. `reti` is ignored.
  - BUSY: `int_req` <= 0, `in_service`=1. `reti` moves to IDLE. `int_ack` is ignored.
- On an accepted ack:
  - The selection is re-evaluated from eligible in the ack cycle; a higher-priority line that arrived after `int_req` rose wins.
  - `int_id` <= selected index, zero-extended to `ID_W`. It is held until the next accepted ack.
  - The selected pending bit is cleared.
  - If eligible is 0 in the ack cycle (e.g. the mask was cleared meanwhile), the ack is dropped and the state stays IDLE.
- Reset values: `int_req`=0, `int_id`=0, `in_service`=0, `pending`=0, mask = all 1s, `irq_prev`=0, state IDLE.
- Reset mid-service discards pending and in-service status. The core is reset with the block.

## Timing
- Line i rises before edge E0:
  - `pending[i]`=1 after E0.
  - `int_req`=1 after E1, a 2-cycle latency from the line rise.
- Ack sampled at edge Ek:
  - After Ek: `int_req`=0, `in_service`=1, `int_id` valid.
  - INTID in the core's next instruction reads the correct value.
- `reti` sampled at edge Er:
  - After Er: `in_service`=0.
  - If eligible != 0 after Er, `int_req`=1 after Er+1; back-to-back service costs 1 idle cycle.
- `int_req` stays high until acked or until eligible becomes 0. The core must not ack when `int_req`=0; such acks are ignored.
- No combinational path from any input to any output except `pending` (register) and `in_service` (state decode).

## Test plan
- Single line:
  - Stimulus: pulse `irq[3]` at cycle 10, ack 3 cycles after `int_req` rises, `reti` 5 cycles later.
  - Required: `pending[3]` set at cycle 11, `int_req` high at cycle 12, `int_id`=3 and `pending[3]`=0 after ack, `in_service` low after `reti`.
- Priority:
  - Stimulus: raise `irq[5]`, and while `int_req` is high raise `irq[1]`, then ack.
  - Required: `int_id`=1, `pending[5]` stays 1; after `reti`, `int_req` re-asserts 1 cycle later and the second ack gives `int_id`=5.
- Masking:
  - Stimulus: write mask 0xFE, then pulse `irq[0]`.
  - Required: `pending[0]`=1 and `int_req` stays 0; write mask 0xFF and `int_req` rises the following cycle.
- No nesting / spurious:
  - Stimulus: during BUSY pulse `irq[2]` and issue `int_ack`; then pulse `reti` while IDLE.
  - Required: the ack is ignored and `int_id` is unchanged; `int_req` rises only after RETI; the stray `reti` has no effect.
- Set/clear collision:
  - Stimulus: a new edge on `irq[4]` in the same cycle as the ack selecting line 4.
  - Required: `pending[4]` remains 1 after the ack.
- Reset mid-service:
  - Stimulus: assert `reset` asynchronously while `in_service`=1 with `pending`=0x0C.
  - Required: all outputs are 0 immediately, without waiting for a clock edge, and the mask reads back as all 1s.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Signal bundle between the interrupt controller and the core/peripheral side.
// The slave modport is the controller; the master modport is the core and its peripherals.
interface interrupt_controller_if #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 8
);
  logic [N_IRQ-1:0] irq;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             int_ack;
  logic             reti;
  logic             int_req;
  logic [ID_W-1:0]  int_id;
  logic             in_service;
  logic [N_IRQ-1:0] pending;

  modport master (
    output irq, mask_we, mask_wdata, int_ack, reti,
    input  int_req, int_id, in_service, pending
  );

  modport slave (
    input  irq, mask_we, mask_wdata, int_ack, reti,
    output int_req, int_id, in_service, pending
  );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-latched, maskable, fixed-priority (lowest index wins) interrupt controller
// delivering one non-nested interrupt at a time to the core.
module interrupt_controller #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  interrupt_controller_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [N_IRQ-1:0] irq_prev_reg;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] mask_reg;
  logic             int_req_reg, int_req_next;
  logic [ID_W-1:0]  int_id_reg;

  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] eligible;
  logic [ID_W-1:0]  sel_idx;
  logic             ack_accept;

  assign edge_det = bus.irq & ~irq_prev_reg;
  assign eligible = pending_reg & mask_reg;

  // Descending scan so the lowest eligible index is the final assignment.
  always_comb begin
    sel_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = ID_W'(i);
    end
  end

  // An ack counts only in IDLE with a request up and something still eligible now.
  assign ack_accept = (state_reg == IDLE) && bus.int_ack && int_req_reg && (eligible != '0);

  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pending
      // A new edge in the clearing cycle keeps the bit set.
      assign pending_next[gi] = edge_det[gi] |
                                (pending_reg[gi] & ~(ack_accept && (sel_idx == ID_W'(gi))));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    int_req_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ack_accept) begin
          state_next = BUSY;
        end else begin
          int_req_next = (eligible != '0);
        end
      end
      BUSY: begin
        if (bus.reti) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      irq_prev_reg <= '0;
      pending_reg  <= '0;
      mask_reg     <= '1;
      int_req_reg  <= 1'b0;
      int_id_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      irq_prev_reg <= bus.irq;
      pending_reg  <= pending_next;
      int_req_reg  <= int_req_next;
      if (bus.mask_we) mask_reg <= bus.mask_wdata;
      if (ack_accept) int_id_reg <= sel_idx;
    end
  end

  assign bus.int_req    = int_req_reg;
  assign bus.int_id     = int_id_reg;
  assign bus.in_service = (state_reg == BUSY);
  assign bus.pending    = pending_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a cycle model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_interrupt_controller;
  localparam int N_IRQ = 8;
  localparam int ID_W  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  interrupt_controller_if #(.N_IRQ(N_IRQ), .ID_W(ID_W)) bus ();

  interrupt_controller #(.N_IRQ(N_IRQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [N_IRQ-1:0] v);
    for (int i = 0; i < N_IRQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: a service flag, request bit, last-serviced id and pending set.
  logic [N_IRQ-1:0] m_pending, m_mask, m_prev;
  logic             m_busy, m_req;
  logic [ID_W-1:0]  m_id;
  logic [N_IRQ-1:0] t_rise, t_elig, t_pend;
  int               t_win;
  bit               t_take;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pending <= '0; m_mask <= '1; m_prev <= '0;
      m_busy <= 1'b0; m_req <= 1'b0; m_id <= '0;
    end else begin
      t_rise = bus.irq & ~m_prev;
      t_elig = m_pending & m_mask;
      t_win  = lowest_set(t_elig);
      t_take = !m_busy && bus.int_ack && m_req && (t_win >= 0);
      t_pend = m_pending;
      if (t_take) t_pend[t_win] = 1'b0;
      m_pending <= t_pend | t_rise;
      m_prev    <= bus.irq;
      if (bus.mask_we) m_mask <= bus.mask_wdata;
      if (m_busy) begin
        m_req <= 1'b0;
        if (bus.reti) m_busy <= 1'b0;
      end else if (t_take) begin
        m_busy <= 1'b1;
        m_req  <= 1'b0;
        m_id   <= ID_W'(t_win);
      end else begin
        m_req <= (t_elig != '0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_int_req",    32'(bus.int_req),    32'(m_req));
      chk("cyc_int_id",     32'(bus.int_id),     32'(m_id));
      chk("cyc_in_service", 32'(bus.in_service), 32'(m_busy));
      chk("cyc_pending",    32'(bus.pending),    32'(m_pending));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_one();
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
  endtask

  task automatic reti_one();
    bus.reti = 1'b1; step(); bus.reti = 1'b0;
  endtask

  initial begin
    bus.irq = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.int_ack = 1'b0; bus.reti = 1'b0;
    step(3);
    chk("reset_int_req", 32'(bus.int_req), 32'h0);
    chk("reset_int_id", 32'(bus.int_id), 32'h0);
    chk("reset_in_service", 32'(bus.in_service), 32'h0);
    chk("reset_pending", 32'(bus.pending), 32'h0);
    reset = 1'b0;
    step(2);

    // Single line 3
    bus.irq = 8'h08; step(); bus.irq = '0;
    chk("single_pending_set", 32'(bus.pending), 32'h08);
    chk("single_req_latency", 32'(bus.int_req), 32'h0);
    step();
    chk("single_req_high", 32'(bus.int_req), 32'h1);
    step(2);
    ack_one();
    chk("single_id", 32'(bus.int_id), 32'h3);
    chk("single_pending_clr", 32'(bus.pending), 32'h0);
    chk("single_in_service", 32'(bus.in_service), 32'h1);
    chk("single_req_drop", 32'(bus.int_req), 32'h0);
    step(4);
    reti_one();
    chk("single_reti", 32'(bus.in_service), 32'h0);
    step();
    chk("single_no_req", 32'(bus.int_req), 32'h0);

    // Spurious ack while idle with no request
    ack_one();
    chk("spurious_ack", 32'(bus.in_service), 32'h0);

    // Priority: line 1 arrives after the request for line 5 rose
    bus.irq = 8'h20; step(); bus.irq = '0;
    step();
    chk("prio_req", 32'(bus.int_req), 32'h1);
    bus.irq = 8'h02; step(); bus.irq = '0;
    chk("prio_pending_both", 32'(bus.pending), 32'h22);
    ack_one();
    chk("prio_id1", 32'(bus.int_id), 32'h1);
    chk("prio_p5_kept", 32'(bus.pending), 32'h20);
    reti_one();
    chk("prio_gap", 32'(bus.int_req), 32'h0);
    step();
    chk("prio_rereq", 32'(bus.int_req), 32'h1);
    ack_one();
    chk("prio_id5", 32'(bus.int_id), 32'h5);
    reti_one();
    step();

    // Masking
    bus.mask_we = 1'b1; bus.mask_wdata = 8'hFE; step(); bus.mask_we = 1'b0;
    bus.irq = 8'h01; step(); bus.irq = '0;
    chk("mask_pending", 32'(bus.pending), 32'h01);
    step(2);
    chk("mask_no_req", 32'(bus.int_req), 32'h0);
    bus.mask_we = 1'b1; bus.mask_wdata = 8'hFF; step(); bus.mask_we = 1'b0;
    chk("mask_write_cycle", 32'(bus.int_req), 32'h0);
    step();
    chk("mask_req", 32'(bus.int_req), 32'h1);
    ack_one();
    chk("mask_id0", 32'(bus.int_id), 32'h0);

    // No nesting: edge and ack during service
    bus.irq = 8'h04; step(); bus.irq = '0;
    ack_one();
    chk("nest_id_kept", 32'(bus.int_id), 32'h0);
    chk("nest_pending", 32'(bus.pending), 32'h04);
    chk("nest_no_req", 32'(bus.int_req), 32'h0);
    reti_one();
    chk("nest_after_reti", 32'(bus.int_req), 32'h0);
    step();
    chk("nest_req", 32'(bus.int_req), 32'h1);
    ack_one();
    chk("nest_id2", 32'(bus.int_id), 32'h2);
    reti_one();
    reti_one();
    chk("stray_reti_svc", 32'(bus.in_service), 32'h0);
    chk("stray_reti_id", 32'(bus.int_id), 32'h2);
    chk("stray_reti_req", 32'(bus.int_req), 32'h0);

    // Set/clear collision on line 4
    bus.irq = 8'h10; step(); bus.irq = '0;
    step();
    bus.irq = 8'h10; bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0; bus.irq = '0;
    chk("coll_id4", 32'(bus.int_id), 32'h4);
    chk("coll_pending", 32'(bus.pending), 32'h10);
    reti_one();
    step();
    ack_one();
    chk("coll_second", 32'(bus.pending), 32'h00);
    reti_one();

    // Reset while in service with lines 2 and 3 pending
    bus.irq = 8'h01; step(); bus.irq = '0;
    step();
    ack_one();
    bus.irq = 8'h0C; step(); bus.irq = '0;
    chk("rst_pre_pending", 32'(bus.pending), 32'h0C);
    chk("rst_pre_svc", 32'(bus.in_service), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_req", 32'(bus.int_req), 32'h0);
    chk("rst_async_id", 32'(bus.int_id), 32'h0);
    chk("rst_async_svc", 32'(bus.in_service), 32'h0);
    chk("rst_async_pending", 32'(bus.pending), 32'h0);
    step(2);
    reset = 1'b0;
    bus.irq = 8'h80; step(); bus.irq = '0;
    step();
    chk("rst_mask_ones", 32'(bus.int_req), 32'h1);
    ack_one();
    chk("rst_id7", 32'(bus.int_id), 32'h7);
    reti_one();
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
